// File: rtl/hist_readout_pkg.sv
// hist_pkg: shared types and helpers for the histogram readout block.
//  rd_state_t      readout FSM states
//  BYTES_PER_WORD  bytes per memory word for the default 128/8 configuration
//  cnt_width()     counter width for a count of n items (never below 1 bit)
package hist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
    FIN
  } rd_state_t;

  localparam int DATA_W_DEFAULT = 128;
  localparam int BYTE_W_DEFAULT = 8;
  localparam int BYTES_PER_WORD = DATA_W_DEFAULT / BYTE_W_DEFAULT;

  // $clog2(1) is 0, which would give a zero-width counter for a
  // one-byte word; clamp to 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hist_readout_if.sv
// hist_readout_if: memory read port plus byte stream of the readout block.
//  mem_addr   read address (master -> memory)
//  mem_rd     read strobe, data returns one cycle later (master -> memory)
//  mem_rdata  read data (memory -> master)
//  out_data   stream byte (master -> sink)
//  out_valid  stream byte valid (master -> sink)
//  out_ready  sink accepts byte (sink -> master)
// master modport: the readout block; slave modport: memory + stream sink.
interface hist_readout_if
  import hist_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 8,
  parameter int BYTE_W = 8
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic [BYTE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/hist_readout_word_serializer.sv
// word_serializer: parallel-load shift register that presents one memory
// word as a sequence of bytes, least significant byte first.
//  clk, reset  clock and synchronous active-high reset
//  load        capture load_data (takes priority over shift)
//  load_data   full memory word
//  shift       drop the current byte (stream handshake)
//  byte_idx    index of the byte currently presented (owned by the FSM)
//  data        current byte
//  last_byte   current byte is the final byte of the word
module word_serializer
  import hist_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  input  logic [CNT_W-1:0]  byte_idx,
  output logic [BYTE_W-1:0] data,
  output logic              last_byte
);

  localparam int BYTES = DATA_W / BYTE_W;

  logic [DATA_W-1:0] shreg_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_reg <= '0;
    end else if (load) begin
      shreg_reg <= load_data;
    end else if (shift) begin
      shreg_reg <= shreg_reg >> BYTE_W;
    end
  end

  assign data      = shreg_reg[BYTE_W-1:0];
  assign last_byte = (byte_idx == CNT_W'(BYTES - 1));

endmodule

// File: rtl/hist_readout.sv
// hist_readout: drains NUM_WORDS words of the histogram memory in address
// order and streams them out as bytes (LS byte of each word first).
//  clk     single clock, rising edge
//  reset   synchronous, active-high
//  start   one-cycle pulse that begins a drain run (ignored unless idle)
//  bus     hist_readout_if.master: memory read port + valid/ready byte stream
//  busy    high from the cycle after start until done
//  done    one-cycle pulse after the last byte has been accepted
// All outputs are registered; out_valid never looks at out_ready
// combinationally.
module hist_readout
  import hist_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 8,
  parameter int NUM_WORDS = 16,
  parameter int BYTE_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  hist_readout_if.master   bus,
  output logic             busy,
  output logic             done
);

  localparam int BYTES = DATA_W / BYTE_W;
  localparam int CNT_W = cnt_width(BYTES);

  rd_state_t         state_reg;
  logic [ADDR_W-1:0] word_cnt_reg;
  logic [CNT_W-1:0]  byte_cnt_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              mem_rd_reg;
  logic              out_valid_reg;
  logic              busy_reg;
  logic              done_reg;

  logic              handshake;
  logic              last_byte;
  logic              last_word;
  logic              load;
  logic [BYTE_W-1:0] ser_data;

  assign handshake = (state_reg == SEND) && out_valid_reg && bus.out_ready;
  assign last_word = (word_cnt_reg == ADDR_W'(NUM_WORDS - 1));
  // Read data arrives during WAIT, one cycle after the FETCH strobe.
  assign load      = (state_reg == WAIT);

  word_serializer #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W),
    .CNT_W  (CNT_W)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (bus.mem_rdata),
    .shift     (handshake),
    .byte_idx  (byte_cnt_reg),
    .data      (ser_data),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      word_cnt_reg  <= '0;
      byte_cnt_reg  <= '0;
      mem_addr_reg  <= '0;
      mem_rd_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      // Strobe-type outputs are one cycle wide unless re-asserted below.
      mem_rd_reg <= 1'b0;
      done_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= FETCH;
            word_cnt_reg <= '0;
            busy_reg     <= 1'b1;
            // Strobe is registered so it is high during the FETCH cycle.
            mem_rd_reg   <= 1'b1;
            mem_addr_reg <= '0;
          end
        end
        FETCH: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          byte_cnt_reg  <= '0;
          out_valid_reg <= 1'b1;
          state_reg     <= SEND;
        end
        SEND: begin
          if (handshake) begin
            if (last_byte) begin
              out_valid_reg <= 1'b0;
              if (last_word) begin
                state_reg <= FIN;
                done_reg  <= 1'b1;
                busy_reg  <= 1'b0;
              end else begin
                word_cnt_reg <= word_cnt_reg + ADDR_W'(1);
                mem_addr_reg <= word_cnt_reg + ADDR_W'(1);
                mem_rd_reg   <= 1'b1;
                state_reg    <= FETCH;
              end
            end else begin
              byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
            end
          end
        end
        FIN: begin
          // A start arriving here is deliberately dropped.
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_rd    = mem_rd_reg;
  assign bus.out_data  = ser_data;
  assign bus.out_valid = out_valid_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_hist_readout.sv
// tb_hist_readout: directed self-checking bench for hist_readout.
// u1 runs with NUM_WORDS=1, u2 with NUM_WORDS=2; both share one memory model.
module tb_hist_readout;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  logic busy1, done1, busy2, done2;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] mem [0:255];

  hist_readout_if #(.DATA_W(128), .ADDR_W(8), .BYTE_W(8)) bus1 ();
  hist_readout_if #(.DATA_W(128), .ADDR_W(8), .BYTE_W(8)) bus2 ();

  hist_readout #(.DATA_W(128), .ADDR_W(8), .NUM_WORDS(1), .BYTE_W(8)) u1 (
    .clk   (clk),
    .reset (reset),
    .start (start1),
    .bus   (bus1),
    .busy  (busy1),
    .done  (done1)
  );

  hist_readout #(.DATA_W(128), .ADDR_W(8), .NUM_WORDS(2), .BYTE_W(8)) u2 (
    .clk   (clk),
    .reset (reset),
    .start (start2),
    .bus   (bus2),
    .busy  (busy2),
    .done  (done2)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency.
  always @(posedge clk) begin
    if (bus1.mem_rd) bus1.mem_rdata <= mem[bus1.mem_addr];
    if (bus2.mem_rd) bus2.mem_rdata <= mem[bus2.mem_addr];
  end

  function automatic logic [7:0] exp_byte(input int w, input int i);
    return (w == 0) ? 8'(i) : 8'(8'hA0 + i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start2();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus1.out_ready = 1'b1;
    bus2.out_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({bus1.mem_addr, bus1.mem_rd, bus1.out_data, bus1.out_valid, busy1, done1} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_u1: got %h expected 0",
               {bus1.mem_addr, bus1.mem_rd, bus1.out_data, bus1.out_valid, busy1, done1});
    end
    n_cmp++;
    if ({bus2.mem_addr, bus2.mem_rd, bus2.out_data, bus2.out_valid, busy2, done2} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_u2: got %h expected 0",
               {bus2.mem_addr, bus2.mem_rd, bus2.out_data, bus2.out_valid, busy2, done2});
    end
    reset = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({busy2, bus2.mem_rd, bus2.out_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_no_start: got %b expected 000", {busy2, bus2.mem_rd, bus2.out_valid});
    end
    $display("test_reset done");
  endtask

  task automatic test_single_word();
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n_cmp++;
    if ({busy1, bus1.mem_rd, bus1.mem_addr, bus1.out_valid} !== {1'b1, 1'b1, 8'd0, 1'b0}) begin
      n_err++;
      $display("FAIL fetch1: got %h expected %h",
               {busy1, bus1.mem_rd, bus1.mem_addr, bus1.out_valid}, {1'b1, 1'b1, 8'd0, 1'b0});
    end
    tick();
    n_cmp++;
    if ({bus1.mem_rd, bus1.out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL wait1: got %b expected 00", {bus1.mem_rd, bus1.out_valid});
    end
    tick();
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if ({bus1.out_valid, bus1.out_data} !== {1'b1, exp_byte(0, i)}) begin
        n_err++;
        $display("FAIL byte1[%0d]: got %h expected %h", i,
                 {bus1.out_valid, bus1.out_data}, {1'b1, exp_byte(0, i)});
      end
      tick();
    end
    n_cmp++;
    if ({done1, busy1, bus1.out_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL done1: got %b expected 100", {done1, busy1, bus1.out_valid});
    end
    tick();
    n_cmp++;
    if ({done1, busy1} !== 2'b00) begin
      n_err++;
      $display("FAIL done1_width: got %b expected 00", {done1, busy1});
    end
    $display("test_single_word done");
  endtask

  task automatic test_two_words();
    bus2.out_ready = 1'b1;
    pulse_start2();
    for (int w = 0; w < 2; w++) begin
      n_cmp++;
      if ({bus2.mem_rd, bus2.mem_addr, bus2.out_valid} !== {1'b1, 8'(w), 1'b0}) begin
        n_err++;
        $display("FAIL fetch2[%0d]: got %h expected %h", w,
                 {bus2.mem_rd, bus2.mem_addr, bus2.out_valid}, {1'b1, 8'(w), 1'b0});
      end
      tick();
      n_cmp++;
      if ({bus2.mem_rd, bus2.out_valid, busy2} !== 3'b001) begin
        n_err++;
        $display("FAIL wait2[%0d]: got %b expected 001", w, {bus2.mem_rd, bus2.out_valid, busy2});
      end
      tick();
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if ({bus2.out_valid, bus2.out_data} !== {1'b1, exp_byte(w, i)}) begin
          n_err++;
          $display("FAIL byte2[%0d][%0d]: got %h expected %h", w, i,
                   {bus2.out_valid, bus2.out_data}, {1'b1, exp_byte(w, i)});
        end
        tick();
      end
    end
    n_cmp++;
    if ({done2, busy2, bus2.out_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL done2: got %b expected 100", {done2, busy2, bus2.out_valid});
    end
    tick();
    tick();
    $display("test_two_words done");
  endtask

  task automatic test_ready_toggle();
    int k = 0;
    logic got_done = 1'b0;
    logic held_v = 1'b0;
    logic [7:0] held_d = 8'd0;
    logic ph = 1'b1;
    pulse_start2();
    for (int c = 0; c < 300 && !got_done; c++) begin
      bus2.out_ready = ph;
      if (held_v) begin
        n_cmp++;
        if ({bus2.out_valid, bus2.out_data} !== {1'b1, held_d}) begin
          n_err++;
          $display("FAIL tog_hold[%0d]: got %h expected %h", c,
                   {bus2.out_valid, bus2.out_data}, {1'b1, held_d});
        end
      end
      if (bus2.out_valid && bus2.out_ready) begin
        n_cmp++;
        if (bus2.out_data !== exp_byte(k / 16, k % 16)) begin
          n_err++;
          $display("FAIL tog_byte[%0d]: got %h expected %h", k, bus2.out_data, exp_byte(k / 16, k % 16));
        end
        k++;
      end
      held_v = bus2.out_valid && !bus2.out_ready;
      held_d = bus2.out_data;
      if (done2) got_done = 1'b1;
      ph = ~ph;
      tick();
    end
    n_cmp++;
    if ({got_done, 32'(k)} !== {1'b1, 32'd32}) begin
      n_err++;
      $display("FAIL tog_count: got done=%0b bytes=%0d expected done=1 bytes=32", got_done, k);
    end
    bus2.out_ready = 1'b1;
    tick();
    tick();
    $display("test_ready_toggle done");
  endtask

  task automatic test_reset_mid();
    int activity = 0;
    bus2.out_ready = 1'b1;
    pulse_start2();
    tick();
    tick();
    for (int s = 0; s < 4; s++) tick();
    n_cmp++;
    if ({bus2.out_valid, bus2.out_data} !== {1'b1, exp_byte(0, 4)}) begin
      n_err++;
      $display("FAIL rst_pre: got %h expected %h", {bus2.out_valid, bus2.out_data}, {1'b1, exp_byte(0, 4)});
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({bus2.mem_addr, bus2.mem_rd, bus2.out_data, bus2.out_valid, busy2, done2} !== 20'd0) begin
      n_err++;
      $display("FAIL rst_mid: got %h expected 0",
               {bus2.mem_addr, bus2.mem_rd, bus2.out_data, bus2.out_valid, busy2, done2});
    end
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done2 || bus2.mem_rd || bus2.out_valid || busy2) activity++;
      tick();
    end
    n_cmp++;
    if (activity !== 0) begin
      n_err++;
      $display("FAIL rst_quiet: got %0d active cycles expected 0", activity);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_start_while_busy();
    int k = 0;
    int dones = 0;
    bus2.out_ready = 1'b1;
    pulse_start2();
    for (int c = 0; c < 120; c++) begin
      // Re-start mid-run and again in the done cycle; both must be ignored.
      start2 = (c == 10) || done2;
      if (bus2.out_valid && bus2.out_ready) begin
        n_cmp++;
        if (bus2.out_data !== exp_byte((k / 16) % 2, k % 16)) begin
          n_err++;
          $display("FAIL busy_byte[%0d]: got %h expected %h", k, bus2.out_data, exp_byte((k / 16) % 2, k % 16));
        end
        k++;
      end
      if (done2) dones++;
      tick();
    end
    start2 = 1'b0;
    n_cmp++;
    if ({32'(k), 32'(dones)} !== {32'd32, 32'd1}) begin
      n_err++;
      $display("FAIL busy_count: got bytes=%0d dones=%0d expected bytes=32 dones=1", k, dones);
    end
    $display("test_start_while_busy done");
  endtask

  task automatic test_stall();
    int bad = 0;
    int k = 5;
    logic got_done = 1'b0;
    bus2.out_ready = 1'b1;
    pulse_start2();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (bus2.out_data !== exp_byte(0, i)) begin
        n_err++;
        $display("FAIL stall_pre[%0d]: got %h expected %h", i, bus2.out_data, exp_byte(0, i));
      end
      tick();
    end
    bus2.out_ready = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if ({bus2.out_valid, bus2.out_data, bus2.mem_rd} !== {1'b1, exp_byte(0, 5), 1'b0}) bad++;
      tick();
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL stall_hold: got %0d bad cycles expected 0", bad);
    end
    bus2.out_ready = 1'b1;
    for (int c = 0; c < 100 && !got_done; c++) begin
      if (bus2.out_valid) begin
        n_cmp++;
        if (bus2.out_data !== exp_byte(k / 16, k % 16)) begin
          n_err++;
          $display("FAIL stall_byte[%0d]: got %h expected %h", k, bus2.out_data, exp_byte(k / 16, k % 16));
        end
        k++;
      end
      if (done2) got_done = 1'b1;
      tick();
    end
    n_cmp++;
    if ({got_done, 32'(k)} !== {1'b1, 32'd32}) begin
      n_err++;
      $display("FAIL stall_count: got done=%0b bytes=%0d expected done=1 bytes=32", got_done, k);
    end
    tick();
    $display("test_stall done");
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = {16{8'hEE}};
    for (int i = 0; i < 16; i++) begin
      mem[0][8*i +: 8] = 8'(i);
      mem[1][8*i +: 8] = 8'(8'hA0 + i);
    end
    bus1.out_ready = 1'b1;
    bus2.out_ready = 1'b1;
    test_reset();
    test_single_word();
    test_two_words();
    test_ready_toggle();
    test_reset_mid();
    test_start_while_busy();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
